// File: rtl/flash_segment_loader_if.sv
// Loader-side and write-port signals of the flash segment loader, grouped as one bundle.
// Carries no logic, so it adds no latency.
// The loader req/ack toggle pair is the only flow control; the write port has no ready.
interface flash_segment_loader_if #(
  parameter int a_bits = 16
);
  logic              ldr_start;
  logic [15:0]       ldr_start_addr;
  logic [23:0]       ldr_flash_offset;
  logic [15:0]       ldr_amount;
  logic              ldr_busy;
  logic              ldr_req;
  logic              ldr_ack;
  logic [a_bits-1:0] ldr_a;
  logic [7:0]        ldr_q;
  logic              wr_strobe;
  logic [a_bits-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [3:0]        wr_seg;

  // Sequencer side: drives loader control and the write port, receives loader writes.
  modport master (
    output ldr_start, ldr_start_addr, ldr_flash_offset, ldr_amount, ldr_ack,
    output wr_strobe, wr_addr, wr_data, wr_seg,
    input  ldr_busy, ldr_req, ldr_a, ldr_q
  );

  // Loader and memory side.
  modport slave (
    input  ldr_start, ldr_start_addr, ldr_flash_offset, ldr_amount, ldr_ack,
    input  wr_strobe, wr_addr, wr_data, wr_seg,
    output ldr_busy, ldr_req, ldr_a, ldr_q
  );
endinterface

// File: rtl/flash_segment_loader.sv
// Sequences SEGS flash segments through one SPI flash loader and holds C64 reset until all are loaded.
// Latency: a loader req toggle becomes a registered wr_strobe one cycle later.
// Backpressure: none on the write port; the loader is paced by the req/ack toggle pair.
module flash_segment_loader #(
  parameter int SEGS       = 4,
  parameter int a_bits     = 16,
  parameter int timeout_ms = 2000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena_1khz,
  input  logic                 slot_valid,
  input  logic [SEGS*16-1:0]   seg_start_addr,
  input  logic [SEGS*24-1:0]   seg_flash_offset,
  input  logic [SEGS*16-1:0]   seg_amount,
  flash_segment_loader_if.master bus,
  output logic [3:0]           cur_seg,
  output logic                 load_done,
  output logic                 load_error,
  output logic                 hold_reset
);

  localparam int MS_W = (timeout_ms < 1) ? 1 : $clog2(timeout_ms + 1);
  localparam logic [MS_W-1:0] MS_LIMIT = MS_W'(timeout_ms);
  localparam logic [3:0] LAST_SEG = 4'(SEGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_RUN,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  logic            slot_valid_old;
  logic            busy_old;
  logic [16:0]     byte_cnt;   // one bit wider than amount so 65535 bytes never wraps
  logic [MS_W-1:0] ms_cnt;

  logic [15:0] cur_amount;
  logic [15:0] cur_addr;
  logic [23:0] cur_offset;
  logic        in_load;
  logic        wr_pend;
  logic        busy_fall;
  logic        slot_rise;
  logic        ms_sat;
  logic [16:0] cnt_final;

  assign cur_amount = seg_amount[cur_seg*16 +: 16];
  assign cur_addr   = seg_start_addr[cur_seg*16 +: 16];
  assign cur_offset = seg_flash_offset[cur_seg*24 +: 24];
  assign in_load    = (state == S_START) || (state == S_WAIT_BUSY) ||
                      (state == S_RUN)   || (state == S_NEXT);
  assign wr_pend    = bus.ldr_req != bus.ldr_ack;
  assign busy_fall  = busy_old & ~bus.ldr_busy;
  assign slot_rise  = slot_valid & ~slot_valid_old;
  assign ms_sat     = ms_cnt == MS_LIMIT;
  // A write arriving together with the busy fall still belongs to this segment.
  assign cnt_final  = byte_cnt + {16'd0, wr_pend};

  // Segment sequencer, write-handshake bridge and progress counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= S_IDLE;
      slot_valid_old       <= 1'b0;
      busy_old             <= 1'b0;
      byte_cnt             <= '0;
      ms_cnt               <= '0;
      cur_seg              <= '0;
      load_done            <= 1'b0;
      load_error           <= 1'b0;
      hold_reset           <= 1'b1;
      bus.ldr_start        <= 1'b0;
      bus.ldr_start_addr   <= '0;
      bus.ldr_flash_offset <= '0;
      bus.ldr_amount       <= '0;
      bus.ldr_ack          <= 1'b0;
      bus.wr_strobe        <= 1'b0;
      bus.wr_addr          <= '0;
      bus.wr_data          <= '0;
      bus.wr_seg           <= '0;
    end else begin
      slot_valid_old <= slot_valid;
      busy_old       <= bus.ldr_busy;
      bus.ldr_start  <= 1'b0;
      bus.wr_strobe  <= 1'b0;

      // While loading, each req toggle becomes one tagged write and counts as progress.
      if (in_load) begin
        if (wr_pend) begin
          bus.wr_strobe <= 1'b1;
          bus.wr_addr   <= bus.ldr_a;
          bus.wr_data   <= bus.ldr_q;
          bus.wr_seg    <= cur_seg;
          bus.ldr_ack   <= bus.ldr_req;
          byte_cnt      <= byte_cnt + 17'd1;
          ms_cnt        <= '0;
        end else if (ena_1khz && !ms_sat) begin
          ms_cnt <= ms_cnt + 1'b1;
        end
      end else begin
        // Stray writes outside a load are acknowledged and dropped.
        bus.ldr_ack <= bus.ldr_req;
      end

      unique case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (slot_rise) begin
            load_done  <= 1'b0;
            load_error <= 1'b0;
            hold_reset <= 1'b1;
            cur_seg    <= '0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (cur_amount == 16'd0) begin
            state <= S_NEXT;
          end else begin
            bus.ldr_start_addr   <= cur_addr;
            bus.ldr_flash_offset <= cur_offset;
            bus.ldr_amount       <= cur_amount;
            bus.ldr_start        <= 1'b1;
            byte_cnt             <= '0;
            ms_cnt               <= '0;
            state                <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (bus.ldr_busy) begin
            state <= S_RUN;
          end else if (ms_sat) begin
            load_error <= 1'b1;
            state      <= S_ERROR;
          end
        end
        S_RUN: begin
          if (busy_fall) begin
            if (cnt_final == {1'b0, bus.ldr_amount}) begin
              state <= S_NEXT;
            end else begin
              load_error <= 1'b1;
              state      <= S_ERROR;
            end
          end else if (ms_sat) begin
            load_error <= 1'b1;
            state      <= S_ERROR;
          end
        end
        S_NEXT: begin
          if (cur_seg == LAST_SEG) begin
            load_done  <= 1'b1;
            hold_reset <= 1'b0;
            state      <= S_DONE;
          end else begin
            cur_seg <= cur_seg + 4'd1;
            state   <= S_START;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_segment_loader.sv
// Bench for flash_segment_loader: a randomized loader model feeds writes, and a queue model checks them.
// Expected write/start streams are computed from the segment configuration alone.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
`timescale 1ns/1ps
module tb_flash_segment_loader;
  localparam int SEGS = 4;
  localparam int AB   = 16;
  localparam int TMO  = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic ena_auto = 1'b1;
  logic ena_tick = 1'b0;
  logic ena_man  = 1'b0;
  logic ena_1khz;
  assign ena_1khz = ena_auto ? ena_tick : ena_man;

  logic slot_valid = 1'b0;
  logic [SEGS*16-1:0] seg_start_addr;
  logic [SEGS*24-1:0] seg_flash_offset;
  logic [SEGS*16-1:0] seg_amount;
  logic [3:0] cur_seg;
  logic load_done, load_error, hold_reset;

  logic [15:0] cfg_sa[SEGS];
  logic [23:0] cfg_off[SEGS];
  logic [15:0] cfg_amt[SEGS];

  flash_segment_loader_if #(.a_bits(AB)) bus ();

  flash_segment_loader #(.SEGS(SEGS), .a_bits(AB), .timeout_ms(TMO)) dut (
    .clk(clk), .reset(reset), .ena_1khz(ena_1khz), .slot_valid(slot_valid),
    .seg_start_addr(seg_start_addr), .seg_flash_offset(seg_flash_offset),
    .seg_amount(seg_amount), .bus(bus), .cur_seg(cur_seg),
    .load_done(load_done), .load_error(load_error), .hold_reset(hold_reset)
  );

  // Pack the per-segment configuration into the flat buses.
  always_comb begin
    seg_start_addr   = '0;
    seg_flash_offset = '0;
    seg_amount       = '0;
    for (int i = 0; i < SEGS; i++) begin
      seg_start_addr[i*16 +: 16]   = cfg_sa[i];
      seg_flash_offset[i*24 +: 24] = cfg_off[i];
      seg_amount[i*16 +: 16]       = cfg_amt[i];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [23:0] off, input int i);
    logic [23:0] s;
    s = off + 24'(i);
    return s[7:0] ^ s[23:16];
  endfunction

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [3:0]  seg;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_start[$];
  int  n_strobe, n_start, n_seg1;
  logic seen_seg1 = 1'b0;
  logic chk_en = 1'b0;

  int fail_seg = -1;
  int short_by = 0;
  logic never_busy = 1'b0;
  logic coincide = 1'b0;
  logic loader_active = 1'b0;

  // Reference: segments in order, zero-amount ones skipped, stream ends at the failing segment.
  task automatic build_expect(input int fs, input int sb);
    exp_wr.delete();
    exp_start.delete();
    for (int s = 0; s < SEGS; s++) begin
      int n;
      if (cfg_amt[s] == 16'd0) continue;
      exp_start.push_back(s);
      n = (s == fs) ? int'(cfg_amt[s]) - sb : int'(cfg_amt[s]);
      for (int i = 0; i < n; i++)
        exp_wr.push_back(wr_t'{addr: cfg_sa[s] + 16'(i), data: byte_of(cfg_off[s], i), seg: 4'(s)});
      if (s == fs) break;
    end
  endtask

  // 1 kHz tick stand-in: one pulse every 40 cycles.
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      c++;
      ena_tick = (c % 40 == 0);
    end
  end

  // Loader model: on each start pulse, raise busy and deliver the bytes by req toggles.
  initial begin
    logic [15:0] l_sa, l_amt;
    logic [23:0] l_off;
    int l_n, l_seg, guard;
    bus.ldr_busy = 1'b0;
    bus.ldr_req  = 1'b0;
    bus.ldr_a    = '0;
    bus.ldr_q    = '0;
    forever begin
      @(negedge clk);
      if (bus.ldr_start === 1'b1 && !never_busy) begin
        loader_active = 1'b1;
        l_sa  = bus.ldr_start_addr;
        l_off = bus.ldr_flash_offset;
        l_amt = bus.ldr_amount;
        l_seg = int'(cur_seg);
        l_n   = int'(l_amt) - ((l_seg == fail_seg) ? short_by : 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus.ldr_busy = 1'b1;
        for (int i = 0; i < l_n; i++) begin
          repeat ($urandom_range(2, 3)) @(negedge clk);
          guard = 0;
          while (bus.ldr_ack !== bus.ldr_req && guard < 20) begin
            @(negedge clk);
            guard++;
          end
          bus.ldr_a   = l_sa + 16'(i);
          bus.ldr_q   = byte_of(l_off, i);
          bus.ldr_req = ~bus.ldr_req;
          if (coincide && i == l_n - 1) bus.ldr_busy = 1'b0;
        end
        if (bus.ldr_busy) begin
          repeat ($urandom_range(2, 3)) @(negedge clk);
          bus.ldr_busy = 1'b0;
        end
        repeat (2) @(negedge clk);
        loader_active = 1'b0;
      end
    end
  end

  // Compare process: every strobe and start pulse against the model queues, every cycle the reset hold.
  always @(negedge clk) begin
    wr_t e;
    int es;
    if (chk_en) begin
      chk("hold_vs_done", 32'(hold_reset), 32'(!load_done));
      if (bus.wr_strobe) begin
        n_strobe++;
        if (bus.wr_seg == 4'd1) begin
          n_seg1++;
          seen_seg1 = 1'b1;
        end
        chk("strobe_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.wr_data), 32'(e.data));
          chk("wr_seg", 32'(bus.wr_seg), 32'(e.seg));
        end
      end
      if (bus.ldr_start) begin
        n_start++;
        chk("start_expected", 32'(exp_start.size() != 0), 1);
        if (exp_start.size() != 0) begin
          es = exp_start.pop_front();
          chk("start_seg", 32'(cur_seg), 32'(es));
          chk("start_addr", 32'(bus.ldr_start_addr), 32'(cfg_sa[es]));
          chk("start_off", 32'(bus.ldr_flash_offset), 32'(cfg_off[es]));
          chk("start_amt", 32'(bus.ldr_amount), 32'(cfg_amt[es]));
        end
      end
    end
  end

  task automatic prepare(input int fs, input int sb, input logic coin, input logic nb);
    fail_seg   = fs;
    short_by   = sb;
    coincide   = coin;
    never_busy = nb;
    build_expect(fs, sb);
    n_strobe   = 0;
    n_start    = 0;
    n_seg1     = 0;
    seen_seg1  = 1'b0;
  endtask

  task automatic kick();
    slot_valid = 1'b0;
    repeat (2) @(negedge clk);
    slot_valid = 1'b1;
    @(negedge clk);
    chk("hold_after_edge", 32'(hold_reset), 1);
    chk("done_after_edge", 32'(load_done), 0);
    chk("err_after_edge", 32'(load_error), 0);
  endtask

  task automatic wait_end();
    int g;
    g = 0;
    while (!(load_done || load_error) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("end_reached", 32'(load_done || load_error), 1);
    g = 0;
    while (loader_active && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("loader_idle", 32'(loader_active), 0);
    repeat (3) @(negedge clk);
    chk("wr_left", 32'(exp_wr.size()), 0);
    chk("start_left", 32'(exp_start.size()), 0);
  endtask

  task automatic check_end(input logic done, input int seg);
    chk("load_done", 32'(load_done), 32'(done));
    chk("load_error", 32'(load_error), 32'(!done));
    chk("hold_reset", 32'(hold_reset), 32'(!done));
    chk("cur_seg", 32'(cur_seg), 32'(seg));
  endtask

  task automatic set_cfg(input int a0, input int a1, input int a2, input int a3);
    cfg_amt[0] = 16'(a0);
    cfg_amt[1] = 16'(a1);
    cfg_amt[2] = 16'(a2);
    cfg_amt[3] = 16'(a3);
    for (int s = 0; s < SEGS; s++) begin
      cfg_sa[s]  = 16'($urandom);
      cfg_off[s] = 24'($urandom);
    end
  endtask

  initial begin
    int g, fs, sb, s, nexp;
    set_cfg(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_error", 32'(load_error), 0);
    chk("rst_hold", 32'(hold_reset), 1);
    chk("rst_cur_seg", 32'(cur_seg), 0);
    chk("rst_start", 32'(bus.ldr_start), 0);
    chk("rst_ack", 32'(bus.ldr_ack), 0);
    chk("rst_strobe", 32'(bus.wr_strobe), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Two segments 4/3, ideal loader.
    set_cfg(4, 3, 0, 0);
    prepare(-1, 0, 1'b0, 1'b0);
    chk("model_len_4_3", 32'(exp_wr.size()), 7);
    chk("model_seg_of_5th", 32'(exp_wr[4].seg), 1);
    kick();
    wait_end();
    check_end(1'b1, SEGS - 1);
    chk("strobes_4_3", 32'(n_strobe), 7);
    chk("seg1_strobes_4_3", 32'(n_seg1), 3);
    chk("starts_4_3", 32'(n_start), 2);

    // Segment 0 skipped.
    set_cfg(0, 2, 0, 0);
    prepare(-1, 0, 1'b0, 1'b0);
    chk("model_first_start", 32'(exp_start[0]), 1);
    kick();
    wait_end();
    check_end(1'b1, SEGS - 1);
    chk("starts_skip", 32'(n_start), 1);
    chk("strobes_skip", 32'(n_strobe), 2);

    // Loader short by one byte in segment 0.
    set_cfg(4, 3, 0, 0);
    prepare(0, 1, 1'b0, 1'b0);
    kick();
    wait_end();
    check_end(1'b0, 0);
    chk("starts_short", 32'(n_start), 1);
    chk("strobes_short", 32'(n_strobe), 3);

    // Busy never asserts: error after exactly TMO ms ticks.
    set_cfg(2, 0, 0, 0);
    prepare(0, 2, 1'b0, 1'b1);
    ena_auto = 1'b0;
    kick();
    g = 0;
    while (bus.ldr_start !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("tmo_start_seen", 32'(bus.ldr_start), 1);
    for (int p = 1; p <= TMO; p++) begin
      @(negedge clk);
      ena_man = 1'b1;
      @(negedge clk);
      ena_man = 1'b0;
      chk("tmo_no_err_yet", 32'(load_error), 0);
      if (p < TMO) begin
        repeat (3) @(negedge clk);
      end else begin
        @(negedge clk);
        chk("tmo_err_after_last_tick", 32'(load_error), 1);
      end
    end
    wait_end();
    check_end(1'b0, 0);
    ena_auto = 1'b1;
    set_cfg(2, 1, 0, 3);
    prepare(-1, 0, 1'b0, 1'b0);
    kick();
    wait_end();
    check_end(1'b1, SEGS - 1);
    chk("strobes_after_tmo", 32'(n_strobe), 6);

    // Last toggle coincides with the busy fall.
    set_cfg(3, 1, 2, 0);
    prepare(-1, 0, 1'b1, 1'b0);
    kick();
    wait_end();
    check_end(1'b1, SEGS - 1);
    chk("strobes_coincide", 32'(n_strobe), 6);

    // Reset pulsed in the middle of segment 1.
    set_cfg(3, 6, 0, 0);
    prepare(-1, 0, 1'b0, 1'b0);
    kick();
    g = 0;
    while (!seen_seg1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("seg1_reached", 32'(seen_seg1), 1);
    reset = 1'b1;
    slot_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_done", 32'(load_done), 0);
    chk("mid_rst_error", 32'(load_error), 0);
    chk("mid_rst_hold", 32'(hold_reset), 1);
    chk("mid_rst_cur_seg", 32'(cur_seg), 0);
    chk("mid_rst_strobe", 32'(bus.wr_strobe), 0);
    chk("mid_rst_ack", 32'(bus.ldr_ack), 0);
    chk("mid_rst_wr_seg", 32'(bus.wr_seg), 0);
    exp_wr.delete();
    exp_start.delete();
    g = 0;
    while (loader_active && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("rst_loader_idle", 32'(loader_active), 0);
    prepare(-1, 0, 1'b0, 1'b0);
    kick();
    wait_end();
    check_end(1'b1, SEGS - 1);
    chk("strobes_reload", 32'(n_strobe), 9);

    // Randomized configurations, occasionally with a short segment.
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < SEGS; k++) begin
        cfg_amt[k] = 16'($urandom_range(0, 5));
        cfg_sa[k]  = 16'($urandom);
        cfg_off[k] = 24'($urandom);
      end
      fs = -1;
      sb = 0;
      if ($urandom_range(0, 2) == 0) begin
        s = int'($urandom_range(0, SEGS - 1));
        if (cfg_amt[s] != 16'd0) begin
          fs = s;
          sb = int'($urandom_range(1, int'(cfg_amt[s])));
        end
      end
      prepare(fs, sb, 1'($urandom_range(0, 1)), 1'b0);
      nexp = exp_wr.size();
      kick();
      wait_end();
      check_end(fs < 0, (fs < 0) ? SEGS - 1 : fs);
      chk("rand_strobes", 32'(n_strobe), 32'(nexp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-length guard.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
